// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: ALU opcodes, writeback selects, multiplier FSM states.
package cpu_types_pkg;

    localparam int WORD_W_DEF = 32;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_MUL  = 4'd11
    } aluop_t;

    typedef enum logic [1:0] {
        RS_ALU = 2'd0,
        RS_MEM = 2'd1,
        RS_PC  = 2'd2,
        RS_IMM = 2'd3
    } regsel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/shift_add_mult.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// state | meaning
// IDLE  | waiting for start
// RUN   | accumulating partial products, busy asserted
// DONE  | product valid for one cycle
module shift_add_mult
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int MUL_STEP = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] multiplicand,
    input  logic [WORD_W-1:0] multiplier,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] product
);
    localparam int STEPS = WORD_W / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS) + 1;

    mul_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] mcand, mplier, partial;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == CNT_W'(STEPS - 1)) state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_comb begin
        partial = product;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) partial = partial + (mcand << i);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else begin
            state <= state_n;
            if (state != RUN && start && !abort) begin
                mcand   <= multiplicand;
                mplier  <= multiplier;
                product <= '0;
                cnt     <= '0;
            end else if (state == RUN) begin
                product <= partial;
                mcand   <= mcand << MUL_STEP;
                mplier  <= mplier >> MUL_STEP;
                cnt     <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// ID/EX pipeline latch plus ALU; presents EX/MEM inputs to the memory stage.
// Define EX_MUL_EN to build the shift-add multiplier; otherwise ALU_MUL yields 0.
module execute_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = WORD_W_DEF,
    parameter int MUL_STEP = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              flush,
    input  logic [WORD_W-1:0] id_nPC,
    input  logic [WORD_W-1:0] id_rdat1,
    input  logic [WORD_W-1:0] id_rdat2,
    input  logic [WORD_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_aluop,
    input  logic              id_ALUSrc,
    input  logic              id_dREN,
    input  logic              id_dWEN,
    input  logic              id_regWr,
    input  logic [1:0]        id_regSel,
    input  logic [4:0]        id_regDst,
    output logic [WORD_W-1:0] nPC,
    output logic [WORD_W-1:0] ALUOut,
    output logic [WORD_W-1:0] storeData,
    output logic              dREN,
    output logic              dWEN,
    output logic              regWr,
    output logic [1:0]        regSel,
    output logic [4:0]        regDst,
    output logic              zero,
    output logic              overflow,
    output logic              mul_busy
);
    aluop_t            op;
    logic [WORD_W-1:0] opb, alu_res, mul_product;
    logic              alu_ovf, mul_done, take;
    logic [WORD_W-1:0] npc_q, alu_q, store_q;
    logic              dren_q, dwen_q, regwr_q, zero_q, ovf_q;
    logic [1:0]        regsel_q;
    logic [4:0]        regdst_q;

    assign op   = aluop_t'(id_aluop);
    assign opb  = id_ALUSrc ? id_imm : id_rdat2;
    assign take = !mul_busy && ihit && !dhit;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            ALU_SLL:  alu_res = opb << id_shamt;
            ALU_SRL:  alu_res = opb >> id_shamt;
            ALU_ADD: begin
                alu_res = id_rdat1 + opb;
                alu_ovf = (id_rdat1[WORD_W-1] == opb[WORD_W-1]) &&
                          (alu_res[WORD_W-1] != id_rdat1[WORD_W-1]);
            end
            ALU_SUB: begin
                alu_res = id_rdat1 - opb;
                alu_ovf = (id_rdat1[WORD_W-1] != opb[WORD_W-1]) &&
                          (alu_res[WORD_W-1] != id_rdat1[WORD_W-1]);
            end
            ALU_AND:  alu_res = id_rdat1 & opb;
            ALU_OR:   alu_res = id_rdat1 | opb;
            ALU_XOR:  alu_res = id_rdat1 ^ opb;
            ALU_NOR:  alu_res = ~(id_rdat1 | opb);
            ALU_SLT:  alu_res = {{(WORD_W-1){1'b0}}, ($signed(id_rdat1) < $signed(opb))};
            ALU_SLTU: alu_res = {{(WORD_W-1){1'b0}}, (id_rdat1 < opb)};
            ALU_LUI:  alu_res = id_imm << 16;
            default:  alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic mul_start;
    assign mul_start = nRST && !flush && take && (op == ALU_MUL);

    shift_add_mult #(
        .WORD_W   (WORD_W),
        .MUL_STEP (MUL_STEP)
    ) u_mult (
        .CLK          (CLK),
        .nRST         (nRST),
        .start        (mul_start),
        .abort        (flush),
        .multiplicand (id_rdat1),
        .multiplier   (opb),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_product)
    );
`else
    logic unused_mul_step;
    assign unused_mul_step = ^MUL_STEP;
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            npc_q    <= '0;
            alu_q    <= '0;
            store_q  <= '0;
            dren_q   <= 1'b0;
            dwen_q   <= 1'b0;
            regwr_q  <= 1'b0;
            regsel_q <= '0;
            regdst_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (!mul_busy) begin
            if (dhit) begin
                dren_q <= 1'b0;
                dwen_q <= 1'b0;
            end
            if (take) begin
                npc_q    <= id_nPC;
                alu_q    <= alu_res;
                store_q  <= id_rdat2;
                dren_q   <= id_dREN;
                dwen_q   <= id_dWEN;
                regwr_q  <= id_regWr;
                regsel_q <= id_regSel;
                regdst_q <= id_regDst;
                zero_q   <= (alu_res == '0);
                ovf_q    <= alu_ovf;
            end else if (mul_done) begin
                // commit the product so it survives the DONE cycle
                alu_q  <= mul_product;
                zero_q <= (mul_product == '0);
                ovf_q  <= 1'b0;
            end
        end
    end

    assign nPC       = npc_q;
    assign ALUOut    = mul_done ? mul_product : alu_q;
    assign storeData = store_q;
    assign dREN      = dren_q & ~mul_busy;
    assign dWEN      = dwen_q & ~mul_busy;
    assign regWr     = regwr_q & ~mul_busy;
    assign regSel    = regsel_q;
    assign regDst    = regdst_q;
    assign zero      = mul_done ? (mul_product == '0) : zero_q;
    assign overflow  = ovf_q & ~mul_done;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- ID/EX pipeline latch plus execute logic for the 5-stage MIPS pipeline.
- Registers decode-stage operands and control, computes the ALU result, and presents the EX/MEM inputs consumed directly by the memory stage.
- Contains an iterative shift-add multiplier; it holds the pipeline while a multiply runs.

Parameters:
- WORD_W, 32, datapath width.
- MUL_STEP, 1, multiplier bits retired per cycle (1, 2 or 4); multiply takes WORD_W/MUL_STEP cycles.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous active-low reset.
- ihit  in  1  instruction fetch complete; pipeline advance enable.
- dhit  in  1  data access complete.
- flush  in  1  squash current contents (branch/jump resolved).
- id_nPC  in  WORD_W  next PC from decode.
- id_rdat1, id_rdat2  in  WORD_W  register operands.
- id_imm  in  WORD_W  extended immediate.
- id_shamt  in  5  shift amount.
- id_aluop  in  4  ALU_SLL/SRL/ADD/SUB/AND/OR/XOR/NOR/SLT/SLTU/LUI/MUL (shared package).
- id_ALUSrc  in  1  1 = use id_imm as operand B.
- id_dREN, id_dWEN, id_regWr  in  1  control.
- id_regSel  in  2  writeback source select.
- id_regDst  in  5  destination register.
- nPC, ALUOut, storeData  out  WORD_W  to memory stage.
- dREN, dWEN, regWr  out  1.
- regSel  out  2.
- regDst  out  5.
- zero, overflow  out  1  ALU flags of latched op.
- mul_busy  out  1  stall request to hazard unit/fetch.

Behaviour:
- Reset (nRST low at a clock edge): all outputs 0, FSM IDLE, step counter 0. This is synchronous only; no asynchronous path.
- Per-edge priority: reset > flush > mul_busy hold > dhit > ihit > hold.
- flush: clear all outputs to reset values and abort any multiply (FSM to IDLE, mul_busy 0 next cycle).
- dhit (not busy): dREN and dWEN go to 0; other outputs hold. This stops repeated memory requests.
- ihit (not busy, no dhit): latch all id_* control fields.
  - ALUOut = f(aluop, rdat1, B), with B = ALUSrc ? imm : rdat2.
  - storeData = rdat2.
  - Latency: 1 cycle from ihit edge.
- Arithmetic rules:
  - ADD/SUB are WORD_W wrap-around. overflow is set on signed overflow; result is still written.
  - SLT is signed, SLTU is unsigned; result is 0 or 1.
  - Shifts use shamt. LUI = imm<<16.
  - zero = (ALUOut == 0).
- Multiply FSM (aluop==ALU_MUL latched on ihit):
  - IDLE -> RUN: capture multiplicand=rdat1 and multiplier=B; clear product; mul_busy=1 from the next cycle.
  - Each RUN cycle retires MUL_STEP multiplier bits; counter increments.
  - RUN -> DONE after WORD_W/MUL_STEP cycles.
  - DONE lasts 1 cycle: ALUOut = low WORD_W bits of the unsigned product, mul_busy=0, zero updated, overflow=0. Then -> IDLE.
  - Total: mul_busy high for exactly WORD_W/MUL_STEP cycles. Result visible the cycle mul_busy falls.
  - While busy: ihit and dhit are ignored; all outputs hold. During RUN, dREN, dWEN and regWr are forced 0 so that the memory stage latches no side effects. regWr is restored in DONE.
- Simultaneous events:
  - flush with ihit: flush wins; nothing is latched.
  - ihit with dhit: dhit wins.
- Reset mid-multiply: FSM returns to IDLE immediately; no result is written.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: multiplier FSM is present and behaves as above.
- Undefined: no FSM or counter. mul_busy is tied 0. ALU_MUL yields ALUOut=0, zero=1, overflow=0, with single-cycle latency like other ops.

Decomposition:
- Package cpu_types_pkg holds:
  - aluop_t enum and its encodings.
  - regsel_t.
  - WORD_W default.
  - mul_state_t {IDLE, RUN, DONE}.
- Natural sub-module: shift_add_mult (start, operands, busy, done, product). execute_stage instantiates it inside the EX_MUL_EN guard.
- ALU stays as combinational logic inside execute_stage.

Test Plan:
- Reset: hold nRST low 2 cycles with ihit=1 and nonzero inputs -> every output 0 and mul_busy 0. Deassert -> nothing latched until ihit.
- ADD overflow: rdat1=0x7FFFFFFF, imm=1, ALUSrc=1, ihit -> next cycle ALUOut=0x80000000, overflow=1, zero=0.
- SLT signed: rdat1=0xFFFFFFFF, rdat2=1, aluop=SLT -> ALUOut=1. Same operands with SLTU -> ALUOut=0, zero=1.
- Load then dhit: id_dREN=1, ihit -> dREN=1. dhit next cycle -> dREN=0 while ALUOut and regDst hold.
- Multiply (MUL_STEP=1): rdat1=7, rdat2=6, ihit -> mul_busy high 32 cycles; ihit pulses ignored. On fall: ALUOut=42, regWr restored.
- Flush mid-multiply: flush at RUN cycle 10 -> next cycle all outputs 0, mul_busy 0. A following ihit with ADD 3+4 -> ALUOut=7.
